// File: rtl/uvmt_reset_st_rst_shaper.sv
// Reset shaper: synchronizes and filters a raw reset request into a shaped reset.
// Glitch counting is built only when UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN is defined.
module uvmt_reset_st_rst_shaper #(
    parameter int FILTER_CYCLES     = 2,
    parameter int MIN_ASSERT_CYCLES = 8,
    parameter int RELEASE_DELAY     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rst_req_n,
    input  logic        cnt_clr,
    output logic        rst_out_n,
    output logic        rst_active,
    output logic [15:0] pulse_count,
    output logic [7:0]  glitch_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILTER  = 2'd1,
        ASSERT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // A FILTER_CYCLES of 1 would otherwise never match; >= keeps FILTER exitable.
    localparam logic [15:0] FILT_LAST = 16'(FILTER_CYCLES - 1);
    localparam logic [15:0] MIN_ASRT  = 16'(MIN_ASSERT_CYCLES);
    localparam logic [15:0] REL_DLY   = 16'(RELEASE_DELAY);

    logic        req_m;
    logic        req_s;
    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic        pulse_inc;
    logic [15:0] pulse_base;
`ifdef UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN
    logic        glitch_inc;
    logic [7:0]  glitch_base;
`endif

    // Two-flop synchronizer; idles high so a reset never looks like a request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_m <= 1'b1;
            req_s <= 1'b1;
        end else begin
            req_m <= rst_req_n;
            req_s <= req_m;
        end
    end

    // Next-state and cycle-counter logic for the shaping FSM.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pulse_inc = 1'b0;
`ifdef UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN
        glitch_inc = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!req_s) begin
                    state_n = FILTER;
                    cnt_n   = 16'd1;
                end
            end
            FILTER: begin
                if (req_s) begin
                    state_n = IDLE;
`ifdef UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN
                    glitch_inc = 1'b1;
`endif
                end else if (cnt >= FILT_LAST) begin
                    state_n   = ASSERT;
                    cnt_n     = 16'd1;
                    pulse_inc = 1'b1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ASSERT: begin
                if (cnt >= MIN_ASRT && req_s) begin
                    state_n = RELEASE;
                    cnt_n   = 16'd1;
                end else if (cnt != 16'hFFFF) begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RELEASE: begin
                if (!req_s) begin
                    state_n = ASSERT;
                    cnt_n   = 16'd1;
                end else if (cnt >= REL_DLY) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 16'd0;
            end
        endcase
    end

    // FSM state and counter registers; reset parks in RELEASE to hold reset out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RELEASE;
            cnt   <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rst_out_n  <= 1'b0;
            rst_active <= 1'b1;
        end else begin
            rst_out_n  <= !(state_n == ASSERT || state_n == RELEASE);
            rst_active <= (state_n != IDLE);
        end
    end

    assign pulse_base = cnt_clr ? 16'd0 : pulse_count;

    // Accepted-pulse counter: clear applies before increment, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pulse_count <= 16'd0;
        end else begin
            pulse_count <= pulse_base + {15'd0, pulse_inc};
        end
    end

`ifdef UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN
    assign glitch_base = cnt_clr ? 8'd0 : glitch_count;

    // Rejected-pulse counter: clear first, then saturating increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            glitch_count <= 8'd0;
        end else if (glitch_inc && glitch_base != 8'hFF) begin
            glitch_count <= glitch_base + 8'd1;
        end else begin
            glitch_count <= glitch_base;
        end
    end
`else
    assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_uvmt_reset_st_rst_shaper.sv
// Directed bench for the reset shaper with default parameters.
// Expected glitch counts follow UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN.
module tb_uvmt_reset_st_rst_shaper;

`ifdef UVMT_RESET_ST_RST_SHAPER_GLITCH_CNT_EN
    localparam int GEN = 1;
`else
    localparam int GEN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rst_req_n;
    logic        cnt_clr;
    logic        rst_out_n;
    logic        rst_active;
    logic [15:0] pulse_count;
    logic [7:0]  glitch_count;

    int n_cmp = 0;
    int n_err = 0;
    int lowcnt;
    logic ok;

    uvmt_reset_st_rst_shaper dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rst_req_n    (rst_req_n),
        .cnt_clr      (cnt_clr),
        .rst_out_n    (rst_out_n),
        .rst_active   (rst_active),
        .pulse_count  (pulse_count),
        .glitch_count (glitch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        rst_req_n = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) tick();
        check("rst_out_in_reset", 32'(rst_out_n), 32'd0);
        check("active_in_reset", 32'(rst_active), 32'd1);
        check("pulse_in_reset", 32'(pulse_count), 32'd0);
        check("glitch_in_reset", 32'(glitch_count), 32'd0);

        // post-reset release: low for 4 more edges, high at the 5th
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (rst_out_n !== 1'b0) ok = 1'b0;
        end
        check("post_rst_low", 32'(ok), 32'd1);
        tick();
        check("post_rst_rise", 32'(rst_out_n), 32'd1);
        check("post_rst_active", 32'(rst_active), 32'd0);
        check("post_rst_pulse", 32'(pulse_count), 32'd0);

        // one-cycle glitch
        rst_req_n = 1'b0;
        tick();
        rst_req_n = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            tick();
            if (rst_out_n !== 1'b1) ok = 1'b0;
        end
        check("glitch_no_out", 32'(ok), 32'd1);
        check("glitch_cnt_1", 32'(glitch_count), 32'(GEN));
        check("glitch_pulse_0", 32'(pulse_count), 32'd0);

        // three-cycle request: falls 3 edges after first low sample
        rst_req_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p3_hold_high", 32'(rst_out_n), 32'd1);
        end
        rst_req_n = 1'b1;
        tick();
        check("p3_fall", 32'(rst_out_n), 32'd0);
        lowcnt = 1;
        for (int i = 0; i < 40 && rst_out_n == 1'b0; i++) begin
            tick();
            if (rst_out_n == 1'b0) lowcnt++;
        end
        check("p3_low_len", 32'(lowcnt), 32'd12);
        check("p3_risen", 32'(rst_out_n), 32'd1);
        check("p3_pulse", 32'(pulse_count), 32'd1);
        check("p3_active", 32'(rst_active), 32'd0);

        // twenty-cycle request: rises 6 edges after first high sample
        rst_req_n = 1'b0;
        repeat (20) tick();
        check("p20_low", 32'(rst_out_n), 32'd0);
        rst_req_n = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            tick();
            if (rst_out_n !== 1'b0) ok = 1'b0;
        end
        check("p20_still_low", 32'(ok), 32'd1);
        tick();
        check("p20_rise", 32'(rst_out_n), 32'd1);
        check("p20_pulse", 32'(pulse_count), 32'd2);

        // re-assert early in RELEASE
        rst_req_n = 1'b0;
        repeat (20) tick();
        rst_req_n = 1'b1;
        repeat (2) tick();
        rst_req_n = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (rst_out_n !== 1'b0) ok = 1'b0;
        end
        rst_req_n = 1'b1;
        repeat (6) begin
            tick();
            if (rst_out_n !== 1'b0) ok = 1'b0;
        end
        check("reasrt_no_rise", 32'(ok), 32'd1);
        tick();
        check("reasrt_rise", 32'(rst_out_n), 32'd1);
        check("reasrt_pulse", 32'(pulse_count), 32'd3);

        // clear together with increment yields 1
        cnt_clr   = 1'b1;
        rst_req_n = 1'b0;
        repeat (4) tick();
        cnt_clr = 1'b0;
        check("clr_inc_out", 32'(rst_out_n), 32'd0);
        check("clr_inc_pulse", 32'(pulse_count), 32'd1);
        check("clr_inc_glitch", 32'(glitch_count), 32'd0);
        rst_req_n = 1'b1;
        for (int i = 0; i < 40 && rst_out_n == 1'b0; i++) tick();
        check("clr_inc_rise", 32'(rst_out_n), 32'd1);
        check("clr_inc_keep", 32'(pulse_count), 32'd1);

        // reset in the middle of a pulse
        rst_req_n = 1'b0;
        repeat (6) tick();
        check("mid_asserted", 32'(rst_out_n), 32'd0);
        reset_n   = 1'b0;
        rst_req_n = 1'b1;
        tick();
        check("mid_rst_out", 32'(rst_out_n), 32'd0);
        check("mid_rst_active", 32'(rst_active), 32'd1);
        check("mid_rst_pulse", 32'(pulse_count), 32'd0);
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (rst_out_n !== 1'b0) ok = 1'b0;
        end
        check("mid_rel_low", 32'(ok), 32'd1);
        tick();
        check("mid_rel_rise", 32'(rst_out_n), 32'd1);

        // 300 glitches: saturation (or constant 0 when not built)
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rst_req_n = 1'b0;
            tick();
            rst_req_n = 1'b1;
            repeat (3) begin
                tick();
                if (rst_out_n !== 1'b1) ok = 1'b0;
            end
        end
        tick();
        check("g300_no_out", 32'(ok), 32'd1);
        check("g300_glitch", 32'(glitch_count), 32'(GEN * 255));
        check("g300_pulse", 32'(pulse_count), 32'd0);

        // clear alone
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_glitch", 32'(glitch_count), 32'd0);
        check("clr_pulse", 32'(pulse_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
